// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: counts valid commutation steps of a 3-line hall sensor
// over a fixed gate window and latches count, direction and fault flags per window.
module hall_speed_meter #(
  parameter int CNT_W       = 8,
  parameter int PRESCALE    = 500000,
  parameter int GATE_TICKS  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       H,
  input  logic             EN,
  output logic [CNT_W-1:0] H_Enc,
  output logic             DIR,
  output logic             VALID,
  output logic             ERR,
  output logic             OVF
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;

  logic [2:0]       sync [SYNC_STAGES];
  logic [2:0]       hs;
  logic [2:0]       cur;
  logic [2:0]       prev;
  logic [PW-1:0]    presc;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] rcnt;
  logic             err_run;
  logic             ovf_run;
  logic             tick;
  logic             win_end;
  logic             fwd;
  logic             rev;
  logic             err_ev;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] enc_sat;

  // Position of a legal code along the forward rotation 001,011,010,110,100,101.
  function automatic logic [2:0] pos(input logic [2:0] code);
    case (code)
      3'b001:  pos = 3'd0;
      3'b011:  pos = 3'd1;
      3'b010:  pos = 3'd2;
      3'b110:  pos = 3'd3;
      3'b100:  pos = 3'd4;
      3'b101:  pos = 3'd5;
      default: pos = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_pos(input logic [2:0] p);
    next_pos = (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      cur  <= '0;
      prev <= '0;
    end else begin
      sync[0] <= H;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      cur  <= hs;
      prev <= cur;
    end
  end

  assign hs = sync[SYNC_STAGES-1];

  // A change out of 000 (power-up / reset state) is neither counted nor flagged;
  // a change out of 111 was already flagged on entry and is ignored.
  always_comb begin
    fwd    = 1'b0;
    rev    = 1'b0;
    err_ev = 1'b0;
    if (cur != prev && prev != 3'b000) begin
      if (cur == 3'b000 || cur == 3'b111) begin
        err_ev = 1'b1;
      end else if (prev != 3'b111) begin
        if (pos(cur) == next_pos(pos(prev)))      fwd    = 1'b1;
        else if (pos(prev) == next_pos(pos(cur))) rev    = 1'b1;
        else                                      err_ev = 1'b1;
      end
    end
  end

  assign tick    = EN && (presc == PW'(PRESCALE - 1));
  assign win_end = tick && (tcnt == TW'(GATE_TICKS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (!EN) begin
      presc <= '0;
      tcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) tcnt <= win_end ? '0 : tcnt + TW'(1);
    end
  end

  // The window-end cycle already belongs to the next window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcnt    <= '0;
      rcnt    <= '0;
      err_run <= 1'b0;
      ovf_run <= 1'b0;
    end else if (!EN) begin
      fcnt    <= '0;
      rcnt    <= '0;
      err_run <= 1'b0;
      ovf_run <= 1'b0;
    end else if (win_end) begin
      fcnt    <= fwd ? CNT_W'(1) : '0;
      rcnt    <= rev ? CNT_W'(1) : '0;
      err_run <= err_ev;
      ovf_run <= 1'b0;
    end else begin
      if (fwd) begin
        if (&fcnt) ovf_run <= 1'b1;
        else       fcnt    <= fcnt + CNT_W'(1);
      end
      if (rev) begin
        if (&rcnt) ovf_run <= 1'b1;
        else       rcnt    <= rcnt + CNT_W'(1);
      end
      if (err_ev) err_run <= 1'b1;
    end
  end

  assign sum     = (CNT_W+1)'(fcnt) + (CNT_W+1)'(rcnt);
  assign enc_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      H_Enc <= '0;
      DIR   <= 1'b0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      VALID <= win_end;
      if (win_end) begin
        H_Enc <= enc_sat;
        DIR   <= (fcnt > rcnt);
        ERR   <= err_run;
        OVF   <= ovf_run;
      end
    end
  end

endmodule

// File: tb/tb_hall_speed_meter.sv
// Directed bench for hall_speed_meter: 12-cycle window instance plus a 24-cycle
// instance, since a 12-cycle window cannot hold enough steps to saturate a 4-bit count.
module tb_hall_speed_meter;

  localparam int CNT_W      = 4;
  localparam int PRESCALE   = 4;
  localparam int GATE_TICKS = 3;

  typedef struct {
    int enc;
    int dir;
    int err;
    int ovf;
    int cyc;
  } rec_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic [2:0]       H;
  logic [CNT_W-1:0] h_enc;
  logic             dir;
  logic             valid;
  logic             err;
  logic             ovf;
  logic [CNT_W-1:0] s_enc;
  logic             s_dir;
  logic             s_valid;
  logic             s_err;
  logic             s_ovf;

  rec_t q_main[$];
  rec_t q_sat[$];
  int   cyc;
  int   num_checks = 0;
  int   num_fails  = 0;

  logic [2:0] fwd_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [2:0] rev_seq [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

  hall_speed_meter #(
    .CNT_W(CNT_W), .PRESCALE(PRESCALE), .GATE_TICKS(GATE_TICKS), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .H(H), .EN(EN),
    .H_Enc(h_enc), .DIR(dir), .VALID(valid), .ERR(err), .OVF(ovf)
  );

  hall_speed_meter #(
    .CNT_W(CNT_W), .PRESCALE(PRESCALE), .GATE_TICKS(6), .SYNC_STAGES(2)
  ) dut_sat (
    .CLK(CLK), .RST(RST), .H(H), .EN(EN),
    .H_Enc(s_enc), .DIR(s_dir), .VALID(s_valid), .ERR(s_err), .OVF(s_ovf)
  );

  initial forever #5 CLK = ~CLK;

  // Record every VALID pulse with the cycle it appeared in.
  initial begin
    rec_t r;
    forever begin
      @(negedge CLK);
      if (valid) begin
        r.enc = int'(h_enc); r.dir = int'(dir); r.err = int'(err); r.ovf = int'(ovf); r.cyc = cyc;
        q_main.push_back(r);
      end
      if (s_valid) begin
        r.enc = int'(s_enc); r.dir = int'(s_dir); r.err = int'(s_err); r.ovf = int'(s_ovf); r.cyc = cyc;
        q_sat.push_back(r);
      end
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] h_val, input logic en_val);
    H  = h_val;
    EN = en_val;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b0;
    H   = 3'b000;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    q_main.delete();
    q_sat.delete();
  endtask

  task automatic check_window(input string tag, input bit sat, input int idx,
                              input int enc, input int dr, input int er, input int ov,
                              input int cyc_exp);
    rec_t r;
    int   n;
    if (sat) n = q_sat.size();
    else     n = q_main.size();
    if (idx >= n) begin
      checkOutput({tag, ".present"}, n, idx + 1);
      return;
    end
    if (sat) r = q_sat[idx];
    else     r = q_main[idx];
    checkOutput({tag, ".enc"}, r.enc, enc);
    checkOutput({tag, ".dir"}, r.dir, dr);
    checkOutput({tag, ".err"}, r.err, er);
    checkOutput({tag, ".ovf"}, r.ovf, ov);
    checkOutput({tag, ".cyc"}, r.cyc, cyc_exp);
  endtask

  initial begin
    logic [2:0] h;
    logic       e;

    RST = 1'b1; EN = 1'b0; H = 3'b000; cyc = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst.enc", int'(h_enc), 0);
    checkOutput("rst.dir", int'(dir), 0);
    checkOutput("rst.valid", int'(valid), 0);
    checkOutput("rst.err", int'(err), 0);
    checkOutput("rst.ovf", int'(ovf), 0);

    $display("[TB] forward rotation");
    do_reset();
    for (int k = 0; k < 37; k++) applyStimulus(fwd_seq[(k / 2) % 6], 1'b1);
    checkOutput("fwd.count", q_main.size(), 3);
    check_window("fwd.w1", 1'b0, 0, 3, 1, 0, 0, 12);
    check_window("fwd.w2", 1'b0, 1, 6, 1, 0, 0, 24);
    check_window("fwd.w3", 1'b0, 2, 6, 1, 0, 0, 36);

    $display("[TB] reverse rotation");
    do_reset();
    for (int k = 0; k < 37; k++) applyStimulus(rev_seq[(k / 2) % 6], 1'b1);
    checkOutput("rev.count", q_main.size(), 3);
    check_window("rev.w2", 1'b0, 1, 6, 0, 0, 0, 24);
    check_window("rev.w3", 1'b0, 2, 6, 0, 0, 0, 36);

    $display("[TB] skip and illegal codes");
    do_reset();
    for (int k = 0; k < 37; k++) begin
      if      (k < 10) h = 3'b001;
      else if (k < 12) h = 3'b010;
      else if (k < 14) h = 3'b110;
      else if (k < 16) h = 3'b111;
      else if (k < 18) h = 3'b000;
      else if (k < 22) h = 3'b001;
      else if (k < 24) h = 3'b011;
      else if (k < 26) h = 3'b010;
      else             h = 3'b110;
      applyStimulus(h, 1'b1);
    end
    checkOutput("fault.count", q_main.size(), 3);
    check_window("fault.w1", 1'b0, 0, 0, 0, 0, 0, 12);
    check_window("fault.w2", 1'b0, 1, 1, 1, 1, 0, 24);
    check_window("fault.w3", 1'b0, 2, 3, 1, 0, 0, 36);

    $display("[TB] saturation");
    do_reset();
    for (int k = 0; k < 73; k++) begin
      if      (k < 20) h = fwd_seq[0];
      else if (k < 40) h = fwd_seq[(k - 19) % 6];
      else             h = fwd_seq[2];
      applyStimulus(h, 1'b1);
    end
    check_window("sat.main.w3", 1'b0, 2, 12, 1, 0, 0, 36);
    checkOutput("sat.count", q_sat.size(), 3);
    check_window("sat.w1", 1'b1, 0, 0, 0, 0, 0, 24);
    check_window("sat.w2", 1'b1, 1, 15, 1, 0, 1, 48);
    check_window("sat.w3", 1'b1, 2, 0, 0, 0, 0, 72);

    $display("[TB] window edge and freeze");
    do_reset();
    for (int k = 0; k < 79; k++) begin
      if      (k < 2)  h = 3'b001;
      else if (k < 8)  h = 3'b011;
      else if (k < 20) h = 3'b010;
      else if (k < 22) h = 3'b100;
      else if (k < 24) h = 3'b101;
      else if (k < 40) h = 3'b001;
      else if (k < 70) h = 3'b011;
      else             h = 3'b010;
      e = !(k >= 36 && k < 66);
      if (k == 66) begin
        checkOutput("freeze.count", q_main.size(), 3);
        checkOutput("freeze.enc", int'(h_enc), 2);
        checkOutput("freeze.dir", int'(dir), 1);
        checkOutput("freeze.err", int'(err), 1);
        checkOutput("freeze.ovf", int'(ovf), 0);
        checkOutput("freeze.valid", int'(valid), 0);
      end
      applyStimulus(h, e);
    end
    checkOutput("edge.count", q_main.size(), 4);
    check_window("edge.w1", 1'b0, 0, 1, 1, 0, 0, 12);
    check_window("edge.w2", 1'b0, 1, 1, 1, 0, 0, 24);
    check_window("edge.w3", 1'b0, 2, 2, 1, 1, 0, 36);
    check_window("edge.w4", 1'b0, 3, 1, 1, 0, 0, 78);

    $display("[TB] reset mid-window");
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if      (k < 2)  h = 3'b001;
      else if (k < 4)  h = 3'b011;
      else if (k < 12) h = 3'b010;
      else if (k < 14) h = 3'b110;
      else             h = 3'b100;
      applyStimulus(h, 1'b1);
    end
    RST = 1'b1;
    #1;
    checkOutput("rstmid.enc", int'(h_enc), 0);
    checkOutput("rstmid.dir", int'(dir), 0);
    checkOutput("rstmid.valid", int'(valid), 0);
    checkOutput("rstmid.err", int'(err), 0);
    checkOutput("rstmid.ovf", int'(ovf), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    for (int k = 0; k < 13; k++) applyStimulus((k < 2) ? 3'b100 : 3'b101, 1'b1);
    checkOutput("rstmid.count", q_main.size(), 2);
    check_window("rstmid.before", 1'b0, 0, 2, 1, 0, 0, 12);
    check_window("rstmid.after", 1'b0, 1, 1, 1, 0, 0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
